// File: rtl/expr_eval_if.sv
// Character-in / result-out handshake bundle for expr_eval.
// The slave modport is the evaluator; the master modport is the environment
// that sources characters and consumes results.
interface expr_eval_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res;
  logic             err;
  logic             res_valid;
  logic             res_ready;

  modport slave (
    input  in, in_valid, res_ready,
    output in_ready, res, err, res_valid
  );

  modport master (
    output in, in_valid, res_ready,
    input  in_ready, res, err, res_valid
  );
endinterface : expr_eval_if

// File: rtl/expr_eval.sv
// expr_eval: consumes an ASCII stream of the form  digit (op digit)* '='
// with op in {'+', '*'}, evaluates it with '*' binding tighter than '+',
// and presents the result (or an error flag) on a valid/ready output.
//
// Evaluation scheme: prod_q holds the running product of the current term,
// sum_q the total of all finished terms. '+' folds prod into sum and
// restarts the term at 1; '=' delivers sum + prod.
module expr_eval #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  typedef enum logic [1:0] {
    S_NUM,  // expecting a digit
    S_OP,   // expecting an operator or '='
    S_ERR,  // malformed, discarding until '='
    S_OUT   // result presented, waiting for the output handshake
  } state_t;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_PLUS,
    C_MUL,
    C_TERM,
    C_ILLEGAL
  } char_class_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [WIDTH-1:0] prod_q,  prod_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             err_q,   err_d;
  logic             res_valid_q, res_valid_d;

  char_class_t      cls;
  logic [3:0]       digit_val;
  logic             accept;
  logic             out_hs;

  // in_ready depends only on state so it never forms a combinational path
  // from in_valid or res_ready.
  assign bus.in_ready  = (state_q != S_OUT);
  assign bus.res       = res_q;
  assign bus.err       = err_q;
  assign bus.res_valid = res_valid_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign out_hs = res_valid_q && bus.res_ready;

  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
  assign digit_val = bus.in[3:0];

  // Classify the presented character.
  always_comb begin
    cls = C_ILLEGAL;
    if (bus.in >= 8'h30 && bus.in <= 8'h39) cls = C_DIGIT;
    else if (bus.in == 8'h2B)               cls = C_PLUS;   // '+'
    else if (bus.in == 8'h2A)               cls = C_MUL;    // '*'
    else if (bus.in == 8'h3D)               cls = C_TERM;   // '='
  end

  // Next-state and datapath update for the grammar FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sum_d       = sum_q;
    prod_d      = prod_q;
    res_d       = res_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      S_NUM: begin
        if (accept) begin
          unique case (cls)
            C_DIGIT: begin
              // prod is 1 at the start of a term, so this loads the digit.
              prod_d  = prod_q * WIDTH'(digit_val);
              state_d = S_OP;
            end
            C_TERM: begin
              // Empty expression or operator followed by '='.
              res_d       = '0;
              err_d       = 1'b1;
              res_valid_d = 1'b1;
              state_d     = S_OUT;
            end
            default: state_d = S_ERR;
          endcase
        end
      end

      S_OP: begin
        if (accept) begin
          unique case (cls)
            C_MUL:   state_d = S_NUM;
            C_PLUS: begin
              sum_d   = sum_q + prod_q;
              prod_d  = WIDTH'(1);
              state_d = S_NUM;
            end
            C_TERM: begin
              res_d       = sum_q + prod_q;
              err_d       = 1'b0;
              res_valid_d = 1'b1;
              state_d     = S_OUT;
            end
            // A digit here would be a multi-digit number, which is illegal.
            default: state_d = S_ERR;
          endcase
        end
      end

      S_ERR: begin
        if (accept && cls == C_TERM) begin
          res_d       = '0;
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end

      S_OUT: begin
        // sum/prod may be left dirty by an aborted expression; they are
        // re-initialised here so the next expression starts clean.
        if (out_hs) begin
          res_valid_d = 1'b0;
          sum_d       = '0;
          prod_d      = WIDTH'(1);
          state_d     = S_NUM;
        end
      end

      default: state_d = S_NUM;
    endcase
  end

  // State register with synchronous clear taking priority over handshakes.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (clr) begin
      state_q     <= S_NUM;
      sum_q       <= '0;
      prod_q      <= WIDTH'(1);
      res_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      prod_q      <= prod_d;
      res_q       <= res_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule : expr_eval

// File: doc/expr_eval.md
# expr_eval

Sequencing controller and evaluator for the ASCII expression stream that the string recognizer validates. It consumes one character per valid/ready handshake and checks the grammar `digit (op digit)* '='`, where op is `+` or `*`. It evaluates the expression with `*` binding tighter than `+`, then presents the result (or an error flag) on a valid/ready output port. It sits between the character source and whatever consumes computed results, replacing the accept/reject-only recognizer where a value is needed.

## Interface
- WIDTH, 32, result/accumulator width in bits
- clk  input  1  clock; all state updates on posedge
- clr  input  1  synchronous, active-high reset; sampled on posedge clk
- in  input  8  ASCII character
- in_valid  input  1  `in` holds a character to consume
- in_ready  output  1  block can accept a character this cycle
- res  output  WIDTH  evaluated result; 0 when err=1
- err  output  1  expression was malformed; qualified by res_valid
- res_valid  output  1  res/err hold a completed expression
- res_ready  input  1  downstream accepts res/err this cycle

## Operation
- Character classes:
  - digit = `"0"`..`"9"` (value in-"0");
  - op = `"+"` or `"*"`;
  - term = `"="`;
  - anything else = illegal.
- Accept event: in_valid && in_ready at posedge.
- No state change occurs without an accept or output handshake.
- Registers:
  - state;
  - sum (WIDTH), committed sum of finished terms;
  - prod (WIDTH), current term's product;
  - res, err, res_valid.
- States and transitions on accept:
  - S_NUM (reset state, expect digit):
    - digit: prod <= prod*d, which is d when starting a term since prod is 1 then; -> S_OP.
    - op, term or illegal: -> S_ERR; term instead goes directly to S_OUT with err=1.
  - S_OP (expect operator or terminator):
    - `*`: -> S_NUM.
    - `+`: sum <= sum+prod; prod <= 1; -> S_NUM.
    - `=`: res <= sum+prod; err <= 0; res_valid <= 1; -> S_OUT.
    - digit or illegal: -> S_ERR.
  - S_ERR: all characters except `=` are consumed and discarded; `=` gives res <= 0, err <= 1, res_valid <= 1, -> S_OUT.
  - S_OUT: no input is accepted. On res_valid && res_ready: res_valid <= 0; sum <= 0; prod <= 1; -> S_NUM.
- On entry to S_NUM at start of an expression: sum=0, prod=1.
- Arithmetic is unsigned, modulo 2^WIDTH; overflow wraps silently with no error.
- Multi-digit numbers are illegal: a digit directly after a digit gives an error.
- An empty expression (`=` first) is an error; so is an operator followed by `=`.

## Timing
- in_ready = (state != S_OUT), purely from state; it does not depend combinationally on in_valid or res_ready.
- Reset values after clr posedge:
  - state=S_NUM, sum=0, prod=1;
  - res=0, err=0, res_valid=0;
  - in_ready=1.
- clr has priority over any simultaneous accept or output handshake. A partial expression or an un-handshaked result is discarded.
- Latency: `=` accepted at edge k gives res_valid=1 from just after edge k.
- res/err are stable while res_valid=1 and res_ready=0.
- Output handshake at edge m: res_valid=0 and in_ready=1 from just after edge m. There is no same-cycle bypass, so the first character of the next expression is accepted at edge m+1 at the earliest.
- Throughput: one character per cycle; each expression costs one extra cycle minimum for the output handshake.
- in_valid held high while in_ready=0: the character is not consumed and must be held by the source.

## Test plan
- Precedence: stream `1+2*3=` back-to-back with res_ready=1 -> res=7, err=0, res_valid high for exactly one cycle, asserted the cycle after `=`.
- Multiple terms: `2*3+4*5=` -> res=26, err=0. Then `9=` -> res=9, confirming sum/prod re-initialise between expressions.
- Errors and recovery:
  - `1++2=` -> err=1, res=0;
  - `12=` -> err=1;
  - `=` -> err=1;
  - `3+=` -> err=1;
  - `a=` -> err=1;
  - each followed by `4*5=` -> res=20, err=0.
- Backpressure: after `5=`, hold res_ready=0 for 5 cycles while presenting `7` with in_valid=1 -> in_ready=0 and res=5 stable throughout. Raise res_ready, then `7` is accepted the next cycle; `7=` -> res=7.
- Reset mid-operation: feed `3*4`, assert clr one cycle, then `8=` -> res=8. Asserting clr while res_valid=1 -> res_valid=0 and in_ready=1 the next cycle.
- Wrap-around: WIDTH=8, `9*9*9*9=` -> res=161 (6561 mod 256), err=0.
